alu_unit: RTL and testbench
===========================

# alu_unit

Execution unit on the dispatch side of the reservation station. It accepts one operation (opcode, two operands, destination ROB tag) per handshake and computes it: in one cycle, or iteratively for shifts. It then holds the result on its broadcast port until the common data bus grants it. The result feeds the RS, LSB and ROB forwarding paths.

## Interface
- ROB_WIDTH, 4, width of ROB tags.
- SHIFT_STEP, 8, maximum shift distance applied per cycle; must be a power of two, 1..32.

- clk_in  in  1  system clock, all state on rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global stall; when low, no state changes.
- clear_signal  in  1  misprediction flush.
- issue_valid  in  1  RS presents an operation.
- opcode  in  4  operation code, encoding below.
- lhs  in  32  operand 1.
- rhs  in  32  operand 2; shifts use rhs[4:0].
- rd_tag  in  ROB_WIDTH  destination tag.
- ready  out  1  unit can accept this cycle (combinational).
- done  out  1  result valid on broadcast port.
- value  out  32  result.
- tag  out  ROB_WIDTH  tag of result.
- cdb_grant  in  1  bus accepts the result presented this cycle.

## Operation

**Opcode encoding**
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU. Opcodes 10..15 produce 32'd1 if the compare is true, else 32'd0.
- Arithmetic is modulo 2^32; no overflow flag. Signed ops use two's complement. SRA replicates lhs[31].

**FSM states**
- IDLE: no operation held.
- SHIFT: shift in progress; a remaining-count register holds 0..31.
- HOLD: result on the port, done=1.

**Accept**
- A handshake occurs when rdy_in & issue_valid & ready & ~clear_signal at a rising edge.
- ready = (state==IDLE) | (state==HOLD & cdb_grant).
- On accept, tag <= rd_tag.
- Opcode not 2/6/7: value <= result, go to HOLD.
- Opcode 2/6/7 with rhs[4:0]==0: value <= lhs, go to HOLD.
- Opcode 2/6/7 otherwise: value <= lhs, remaining <= rhs[4:0], latch the shift kind, go to SHIFT.

**SHIFT**
- Each enabled edge: step = min(remaining, SHIFT_STEP); shift value by step; remaining -= step.
- When remaining reaches 0 at that edge, go to HOLD.
- issue_valid is ignored while in SHIFT.

**HOLD**
- done, value and tag stay stable until an edge with rdy_in & cdb_grant.
- At that edge: if a new accept also occurs, process it as above (back-to-back). Otherwise go to IDLE and set done <= 0.

**Flush**
- rdy_in & clear_signal at an edge forces IDLE and done <= 0 from any state.
- No accept happens on that edge.

**Stall**
- rdy_in low freezes all registers.
- done/value/tag keep their values; ready is still computed from the current state.

## Timing
- Reset (async, rst_in low): state IDLE, done 0, value 0, tag 0, remaining 0. ready reads 1 while in reset.
- Non-shift and zero-shift ops: done rises 1 cycle after the accept edge.
- Shift by s (1..31): done rises 1 + ceil(s/SHIFT_STEP) cycles after the accept edge. With the default step: s=8 gives 2, s=9 gives 3, s=31 gives 5.
- Sustained throughput of 1 op/cycle for non-shift ops while cdb_grant stays high.
- When grant and flush coincide, flush wins; the result is discarded.
- Reset asserted mid-SHIFT or mid-HOLD returns to the reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, then ADD lhs=0xFFFFFFFF rhs=1 tag=3, grant held high -> next cycle done=1, value=0, tag=3; the following cycle done=0.
- SLT lhs=0x80000000 rhs=1 -> value=1. SLTU with the same operands -> value=0. GEU lhs=5 rhs=5 -> value=1.
- SRA lhs=0x80000000 rhs=31, grant high -> done exactly 5 cycles after accept, value=0xFFFFFFFF. issue_valid held high meanwhile -> ready=0 and no accept.
- Result held with cdb_grant=0 for 4 cycles -> done/value/tag stable, ready=0. Then raise grant with a new XOR (0xF0F0, 0x0FF0, tag 7) -> next cycle value=0xFF00, tag=7.
- clear_signal during SHIFT (SLL rhs=20) and, separately, during HOLD -> next cycle IDLE, done=0, ready=1. An issue presented on the flush edge is dropped.
- rdy_in low for 3 cycles mid-SHIFT -> latency extends by 3, result unchanged. rst_in pulsed low between clock edges -> done drops to 0 without waiting for an edge.

Source files
------------

// File: rtl/alu_unit.sv
// alu_unit: single-issue integer execution unit behind the reservation station.
// Accepts one operation per handshake. It computes most operations in a single
// cycle. Shifts are done iteratively, moving at most SHIFT_STEP bit positions
// per cycle. The result is held on the broadcast port until the common data
// bus grants it.
//
// Ports
//   clk_in        system clock, rising edge
//   rst_in        asynchronous reset, active low
//   rdy_in        global stall; low freezes every register
//   clear_signal  misprediction flush (returns to IDLE, drops the result)
//   issue_valid   RS presents opcode/lhs/rhs/rd_tag
//   opcode        4-bit operation code
//   lhs, rhs      operands; shifts use rhs[4:0] as the distance
//   rd_tag        destination ROB tag
//   ready         unit can take an operation this cycle (combinational)
//   done          result valid on value/tag
//   value, tag    broadcast result and its ROB tag
//   cdb_grant     bus takes the presented result this cycle
//
// state | meaning
// IDLE  | nothing held; ready
// SHIFT | iterative shift in progress; rem_q bit positions still to go
// HOLD  | result on the port with done=1; waiting for cdb_grant

module alu_unit #(
  parameter int ROB_WIDTH  = 4,
  parameter int SHIFT_STEP = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  input  logic                 issue_valid,
  input  logic [3:0]           opcode,
  input  logic [31:0]          lhs,
  input  logic [31:0]          rhs,
  input  logic [ROB_WIDTH-1:0] rd_tag,
  output logic                 ready,
  output logic                 done,
  output logic [31:0]          value,
  output logic [ROB_WIDTH-1:0] tag,
  input  logic                 cdb_grant
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_EQ   = 4'd10,
    OP_NE   = 4'd11,
    OP_LT   = 4'd12,
    OP_GE   = 4'd13,
    OP_LTU  = 4'd14,
    OP_GEU  = 4'd15
  } op_e;

  localparam logic [5:0] STEP_MAX = 6'(SHIFT_STEP);

  state_e               state_q;
  logic [31:0]          value_q;
  logic [ROB_WIDTH-1:0] tag_q;
  logic                 done_q;
  logic [4:0]           rem_q;
  op_e                  kind_q;

  logic        accept;
  logic        is_shift;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic        lt_s;
  logic        lt_u;
  logic        eq;
  logic [5:0]  rem_ext;
  logic [5:0]  step;
  logic [31:0] shift_val_d;
  logic [4:0]  rem_d;

  assign ready  = (state_q == S_IDLE) | ((state_q == S_HOLD) & cdb_grant);
  assign accept = rdy_in & issue_valid & ready & ~clear_signal;

  assign done  = done_q;
  assign value = value_q;
  assign tag   = tag_q;

  assign shamt    = rhs[4:0];
  assign is_shift = (opcode == OP_SLL) | (opcode == OP_SRL) | (opcode == OP_SRA);

  assign lt_s = $signed(lhs) < $signed(rhs);
  assign lt_u = lhs < rhs;
  assign eq   = lhs == rhs;

  // Single-cycle result; shift opcodes never use this path.
  always_comb begin
    alu_res = '0;
    case (op_e'(opcode))
      OP_ADD:  alu_res = lhs + rhs;
      OP_SUB:  alu_res = lhs - rhs;
      OP_SLT:  alu_res = {31'd0, lt_s};
      OP_SLTU: alu_res = {31'd0, lt_u};
      OP_XOR:  alu_res = lhs ^ rhs;
      OP_OR:   alu_res = lhs | rhs;
      OP_AND:  alu_res = lhs & rhs;
      OP_EQ:   alu_res = {31'd0, eq};
      OP_NE:   alu_res = {31'd0, ~eq};
      OP_LT:   alu_res = {31'd0, lt_s};
      OP_GE:   alu_res = {31'd0, ~lt_s};
      OP_LTU:  alu_res = {31'd0, lt_u};
      OP_GEU:  alu_res = {31'd0, ~lt_u};
      default: alu_res = '0;
    endcase
  end

  // One shift iteration: move by min(remaining, SHIFT_STEP).
  always_comb begin
    rem_ext = {1'b0, rem_q};
    step    = (rem_ext < STEP_MAX) ? rem_ext : STEP_MAX;
    rem_d   = rem_q - step[4:0];
    case (kind_q)
      OP_SRL:  shift_val_d = value_q >> step;
      OP_SRA:  shift_val_d = 32'($signed(value_q) >>> step);
      default: shift_val_d = value_q << step;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      value_q <= '0;
      tag_q   <= '0;
      done_q  <= 1'b0;
      rem_q   <= '0;
      kind_q  <= OP_SLL;
    end else if (rdy_in) begin
      if (clear_signal) begin
        state_q <= S_IDLE;
        done_q  <= 1'b0;
      end else if (accept) begin
        // accept is only possible from IDLE or from HOLD being granted,
        // so it covers the back-to-back case as well.
        tag_q <= rd_tag;
        if (!is_shift) begin
          value_q <= alu_res;
          done_q  <= 1'b1;
          state_q <= S_HOLD;
        end else if (shamt == 5'd0) begin
          value_q <= lhs;
          done_q  <= 1'b1;
          state_q <= S_HOLD;
        end else begin
          value_q <= lhs;
          rem_q   <= shamt;
          kind_q  <= op_e'(opcode);
          done_q  <= 1'b0;
          state_q <= S_SHIFT;
        end
      end else begin
        case (state_q)
          S_SHIFT: begin
            value_q <= shift_val_d;
            rem_q   <= rem_d;
            if (rem_d == 5'd0) begin
              done_q  <= 1'b1;
              state_q <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (cdb_grant) begin
              done_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;
  localparam int RW   = 4;
  localparam int STEP = 8;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          clear_signal;
  logic          issue_valid;
  logic [3:0]    opcode;
  logic [31:0]   lhs;
  logic [31:0]   rhs;
  logic [RW-1:0] rd_tag;
  logic          ready;
  logic          done;
  logic [31:0]   value;
  logic [RW-1:0] tag;
  logic          cdb_grant;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  alu_unit #(.ROB_WIDTH(RW), .SHIFT_STEP(STEP)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
    .issue_valid(issue_valid), .opcode(opcode), .lhs(lhs), .rhs(rhs), .rd_tag(rd_tag),
    .ready(ready), .done(done), .value(value), .tag(tag), .cdb_grant(cdb_grant)
  );

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << s;
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> s;
      4'd7:  return 32'($signed(a) >>> s);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return (a == b) ? 32'd1 : 32'd0;
      4'd11: return (a != b) ? 32'd1 : 32'd0;
      4'd12: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd13: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd14: return (a < b) ? 32'd1 : 32'd0;
      default: return (a >= b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    if ((op == 4'd2 || op == 4'd6 || op == 4'd7) && s != 0)
      return 1 + (s + STEP - 1) / STEP;
    return 1;
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [RW-1:0] t);
    issue_valid = 1'b1;
    opcode      = op;
    lhs         = a;
    rhs         = b;
    rd_tag      = t;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; clear_signal = 1'b0; issue_valid = 1'b0;
    opcode = '0; lhs = '0; rhs = '0; rd_tag = '0; cdb_grant = 1'b0;
    #2;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (value !== 32'd0) begin fails++; $display("FAIL reset_value: got %h want 0", value); end
    tests++; if (tag !== '0) begin fails++; $display("FAIL reset_tag: got %h want 0", tag); end
    @(negedge clk_in);
    rst_in = 1'b1;
    cyc();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL post_reset_done: got %b want 0", done); end
  endtask

  task automatic test_add_wrap();
    drive(4'd0, 32'hFFFF_FFFF, 32'd1, 4'd3);
    cdb_grant = 1'b1;
    cyc();
    issue_valid = 1'b0;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL add_done: got %b want 1", done); end
    tests++; if (value !== 32'd0) begin fails++; $display("FAIL add_value: got %h want 0", value); end
    tests++; if (tag !== 4'd3) begin fails++; $display("FAIL add_tag: got %h want 3", tag); end
    cyc();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL add_release: got %b want 0", done); end
  endtask

  task automatic test_single_cycle_ops();
    logic [3:0]  dop [3];
    logic [31:0] da  [3];
    logic [31:0] db  [3];
    logic [3:0]  ops_ns [13];
    logic [3:0]  op;
    logic [31:0] a, b, exp;
    logic [RW-1:0] t;
    dop[0] = 4'd3;  da[0] = 32'h8000_0000; db[0] = 32'd1;
    dop[1] = 4'd4;  da[1] = 32'h8000_0000; db[1] = 32'd1;
    dop[2] = 4'd15; da[2] = 32'd5;         db[2] = 32'd5;
    ops_ns = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    cdb_grant = 1'b1;
    for (int k = 0; k < 43; k++) begin
      if (k < 3) begin
        op = dop[k]; a = da[k]; b = db[k];
      end else begin
        op = ops_ns[$urandom_range(0, 12)];
        a  = $urandom;
        case ($urandom_range(0, 3))
          0: b = a;
          1: b = a + 32'($urandom_range(0, 2)) - 32'd1;
          default: b = $urandom;
        endcase
      end
      t   = RW'($urandom);
      exp = model(op, a, b);
      drive(op, a, b, t);
      cyc();
      issue_valid = 1'b0;
      tests++; if (done !== 1'b1 || value !== exp || tag !== t)
        begin fails++; $display("FAIL op%0d a=%h b=%h: got done=%b value=%h tag=%h want 1 %h %h", op, a, b, done, value, tag, exp, t); end
      cyc();
    end
  endtask

  task automatic test_shift();
    logic [3:0]  op;
    logic [31:0] a, b, exp;
    logic [RW-1:0] t;
    int n, lat;
    int dsh [5];
    dsh = '{31, 8, 9, 0, 1};
    cdb_grant = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (k == 0) begin
        op = 4'd7; a = 32'h8000_0000; b = 32'd31;
      end else begin
        case ($urandom_range(0, 2))
          0: op = 4'd2;
          1: op = 4'd6;
          default: op = 4'd7;
        endcase
        a = $urandom;
        b = (k < 5) ? 32'(dsh[k]) : 32'($urandom);
      end
      t   = RW'($urandom);
      exp = model(op, a, b);
      lat = model_lat(op, b);
      drive(op, a, b, t);
      cyc();
      // keep offering a different op; it must not be taken while shifting
      opcode = 4'd0; rd_tag = ~t;
      n = 1;
      while (done !== 1'b1 && n < 20) begin
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL shift_ready: got %b want 0 at cycle %0d", ready, n); end
        cyc();
        n++;
      end
      issue_valid = 1'b0;
      tests++; if (n != lat) begin fails++; $display("FAIL shift_latency op%0d s=%0d: got %0d want %0d", op, b[4:0], n, lat); end
      tests++; if (value !== exp) begin fails++; $display("FAIL shift_value op%0d a=%h s=%0d: got %h want %h", op, a, b[4:0], value, exp); end
      tests++; if (tag !== t) begin fails++; $display("FAIL shift_tag: got %h want %h", tag, t); end
      cyc();
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL shift_release: got %b want 0", done); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops_ns [13];
    logic [3:0]  op;
    logic [31:0] a, b, exp_prev;
    logic [RW-1:0] t_prev;
    ops_ns = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    cdb_grant = 1'b1;
    exp_prev = '0; t_prev = '0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin
        tests++; if (done !== 1'b1 || value !== exp_prev || tag !== t_prev || ready !== 1'b1)
          begin fails++; $display("FAIL b2b[%0d]: got done=%b value=%h tag=%h ready=%b want 1 %h %h 1", k, done, value, tag, ready, exp_prev, t_prev); end
      end
      op = ops_ns[$urandom_range(0, 12)];
      a = $urandom; b = $urandom;
      exp_prev = model(op, a, b);
      t_prev = RW'(k);
      drive(op, a, b, t_prev);
      cyc();
    end
    issue_valid = 1'b0;
    tests++; if (done !== 1'b1 || value !== exp_prev || tag !== t_prev)
      begin fails++; $display("FAIL b2b_last: got done=%b value=%h tag=%h want 1 %h %h", done, value, tag, exp_prev, t_prev); end
    cyc();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_release: got %b want 0", done); end
  endtask

  task automatic test_hold_grant();
    cdb_grant = 1'b0;
    drive(4'd0, 32'd10, 32'd20, 4'd5);
    cyc();
    drive(4'd5, 32'h0000_F0F0, 32'h0000_0FF0, 4'd7);
    for (int k = 0; k < 4; k++) begin
      tests++; if (done !== 1'b1 || value !== 32'd30 || tag !== 4'd5 || ready !== 1'b0)
        begin fails++; $display("FAIL hold[%0d]: got done=%b value=%h tag=%h ready=%b want 1 1e 5 0", k, done, value, tag, ready); end
      cyc();
    end
    cdb_grant = 1'b1;
    #1;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL hold_grant_ready: got %b want 1", ready); end
    @(negedge clk_in);
    issue_valid = 1'b0;
    tests++; if (done !== 1'b1 || value !== 32'h0000_FF00 || tag !== 4'd7)
      begin fails++; $display("FAIL hold_next_xor: got done=%b value=%h tag=%h want 1 ff00 7", done, value, tag); end
    cyc();
  endtask

  task automatic test_flush();
    cdb_grant = 1'b0;
    drive(4'd2, $urandom, 32'd20, 4'd2);
    cyc();
    issue_valid = 1'b0;
    cyc();
    tests++; if (ready !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL flush_shift_pre: got ready=%b done=%b want 0 0", ready, done); end
    clear_signal = 1'b1; cdb_grant = 1'b1;
    drive(4'd0, 32'd1, 32'd2, 4'd9);
    cyc();
    clear_signal = 1'b0; issue_valid = 1'b0;
    tests++; if (done !== 1'b0 || ready !== 1'b1) begin fails++; $display("FAIL flush_shift: got done=%b ready=%b want 0 1", done, ready); end
    cyc();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL flush_shift_drop: got %b want 0", done); end

    cdb_grant = 1'b0;
    drive(4'd0, 32'd4, 32'd4, 4'd1);
    cyc();
    tests++; if (done !== 1'b1 || value !== 32'd8) begin fails++; $display("FAIL flush_hold_pre: got done=%b value=%h want 1 8", done, value); end
    clear_signal = 1'b1; cdb_grant = 1'b1;
    drive(4'd0, 32'd1, 32'd2, 4'd9);
    cyc();
    clear_signal = 1'b0; issue_valid = 1'b0;
    tests++; if (done !== 1'b0 || ready !== 1'b1) begin fails++; $display("FAIL flush_hold: got done=%b ready=%b want 0 1", done, ready); end
    cyc();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL flush_hold_drop: got %b want 0", done); end
  endtask

  task automatic test_rdy_stall();
    logic [31:0] a, exp;
    int n;
    a = $urandom;
    exp = model(4'd6, a, 32'd20);
    cdb_grant = 1'b1;
    drive(4'd6, a, 32'd20, 4'd4);
    cyc();
    issue_valid = 1'b0;
    cyc();
    n = 2;
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n++;
      tests++; if (done !== 1'b0 || ready !== 1'b0) begin fails++; $display("FAIL stall_shift[%0d]: got done=%b ready=%b want 0 0", k, done, ready); end
    end
    rdy_in = 1'b1;
    while (done !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    tests++; if (n != model_lat(4'd6, 32'd20) + 3) begin fails++; $display("FAIL stall_latency: got %0d want %0d", n, model_lat(4'd6, 32'd20) + 3); end
    tests++; if (value !== exp || tag !== 4'd4) begin fails++; $display("FAIL stall_value: got %h tag %h want %h 4", value, tag, exp); end
    rdy_in = 1'b0;
    cyc();
    cyc();
    tests++; if (done !== 1'b1 || value !== exp) begin fails++; $display("FAIL stall_hold: got done=%b value=%h want 1 %h", done, value, exp); end
    rdy_in = 1'b1;
    cyc();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL stall_release: got %b want 0", done); end
  endtask

  task automatic test_async_reset();
    cdb_grant = 1'b0;
    drive(4'd1, 32'd9, 32'd2, 4'd6);
    cyc();
    issue_valid = 1'b0;
    tests++; if (done !== 1'b1 || value !== 32'd7) begin fails++; $display("FAIL areset_pre: got done=%b value=%h want 1 7", done, value); end
    #2 rst_in = 1'b0;
    #1;
    tests++; if (done !== 1'b0 || value !== 32'd0 || tag !== '0 || ready !== 1'b1)
      begin fails++; $display("FAIL areset_hold: got done=%b value=%h tag=%h ready=%b want 0 0 0 1", done, value, tag, ready); end
    #1 rst_in = 1'b1;
    @(negedge clk_in);

    drive(4'd2, 32'd1, 32'd31, 4'd8);
    cyc();
    issue_valid = 1'b0;
    cyc();
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL areset_shift_pre: got ready=%b want 0", ready); end
    #2 rst_in = 1'b0;
    #1;
    tests++; if (done !== 1'b0 || value !== 32'd0 || ready !== 1'b1)
      begin fails++; $display("FAIL areset_shift: got done=%b value=%h ready=%b want 0 0 1", done, value, ready); end
    #1 rst_in = 1'b1;
    @(negedge clk_in);
    cyc();
    tests++; if (done !== 1'b0 || ready !== 1'b1) begin fails++; $display("FAIL areset_after: got done=%b ready=%b want 0 1", done, ready); end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_single_cycle_ops();
    test_shift();
    test_back_to_back();
    test_hold_grant();
    test_flush();
    test_rdy_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
